// File: rtl/ram_port_arbiter_if.sv
// Bundle between two requesters, the arbiter and a single-port synchronous RAM.
// slave = arbiter side; master = requesters plus the RAM model.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    // valid/ready: a request is accepted in any cycle where rn_valid and rn_ready are both
    // high; rn_ready is combinational, never high without rn_valid, and the requester keeps
    // its fields stable while valid is high and ready is low.
    logic              r0_valid, r0_we, r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r1_valid, r1_we, r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;

    logic              r0_ready, r0_rsp_valid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r1_ready, r1_rsp_valid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_ce, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic [1:0]        arb_state;

    modport slave (
        input  r0_valid, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r1_valid, r1_we, r1_lock, r1_addr, r1_wdata,
        input  mem_dout,
        output r0_ready, r0_rsp_valid, r0_rdata,
        output r1_ready, r1_rsp_valid, r1_rdata,
        output mem_ce, mem_we, mem_addr, mem_din,
        output arb_state
    );

    modport master (
        output r0_valid, r0_we, r0_lock, r0_addr, r0_wdata,
        output r1_valid, r1_we, r1_lock, r1_addr, r1_wdata,
        output mem_dout,
        input  r0_ready, r0_rsp_valid, r0_rdata,
        input  r1_ready, r1_rsp_valid, r1_rdata,
        input  mem_ce, mem_we, mem_addr, mem_din,
        input  arb_state
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter with lock/hold in front of a 1-cycle-latency RAM.
// Define RAM_ARB_STATS_EN to add per-requester saturating grant counters (stat_sel/stat_count).
module ram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic                stat_sel,
    output logic [15:0]         stat_count
`endif
);
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              prio, prio_nxt;
    logic              pending, owner;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARB;
            prio    <= 1'b0;
            pending <= 1'b0;
            owner   <= 1'b0;
        end else begin
            state   <= state_nxt;
            prio    <= prio_nxt;
            pending <= (gnt0 & ~bus.r0_we) | (gnt1 & ~bus.r1_we);
            owner   <= gnt1;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            ARB: begin
                if (gnt0) begin
                    prio_nxt = 1'b1;
                    if (bus.r0_lock) state_nxt = HOLD0;
                end else if (gnt1) begin
                    prio_nxt = 1'b0;
                    if (bus.r1_lock) state_nxt = HOLD1;
                end
            end
            HOLD0:   if (!bus.r0_valid || !bus.r0_lock) state_nxt = ARB;
            HOLD1:   if (!bus.r1_valid || !bus.r1_lock) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Grants are gated by reset so ready/mem_ce stay low while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state)
                ARB: begin
                    if (bus.r0_valid && bus.r1_valid) begin
                        gnt0 = ~prio;
                        gnt1 = prio;
                    end else begin
                        gnt0 = bus.r0_valid;
                        gnt1 = bus.r1_valid;
                    end
                end
                HOLD0:   gnt0 = bus.r0_valid;
                HOLD1:   gnt1 = bus.r1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        if (gnt0) begin
            sel_addr = bus.r0_addr;
            sel_din  = bus.r0_wdata;
        end else if (gnt1) begin
            sel_addr = bus.r1_addr;
            sel_din  = bus.r1_wdata;
        end
    end

    assign bus.r0_ready     = gnt0;
    assign bus.r1_ready     = gnt1;
    assign bus.mem_ce       = gnt0 | gnt1;
    assign bus.mem_we       = (gnt0 & bus.r0_we) | (gnt1 & bus.r1_we);
    assign bus.mem_addr     = sel_addr;
    assign bus.mem_din      = sel_din;
    assign bus.r0_rsp_valid = pending & ~owner;
    assign bus.r1_rsp_valid = pending & owner;
    assign bus.r0_rdata     = (pending & ~owner) ? bus.mem_dout : '0;
    assign bus.r1_rdata     = (pending & owner)  ? bus.mem_dout : '0;
    assign bus.arb_state    = state;

`ifdef RAM_ARB_STATS_EN
    logic [15:0] cnt0, cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (gnt1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end

    assign stat_count = stat_sel ? cnt1 : cnt0;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_ram_port_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic reset;
`ifdef RAM_ARB_STATS_EN
    logic        stat_sel;
    logic [15:0] stat_count;
`endif

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave)
`ifdef RAM_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM environment: read-first, one-cycle latency
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= ram[bus.mem_addr];
        end
    end

    // reference model state
    logic [DATA_W-1:0] mdl_mem [0:DEPTH-1];
    int                mdl_hold;      // -1 = arbitrating, else locked requester
    int                mdl_prio;
    int                exp_owner;     // -1 = no response expected this cycle
    logic [DATA_W-1:0] exp_data;
    int unsigned       grant_cnt [2];
    logic [DATA_W-1:0] exp_q [$];     // read data in acceptance order

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_hold  = -1;
        mdl_prio  = 0;
        exp_owner = -1;
        exp_data  = '0;
        exp_q.delete();
        grant_cnt[0] = 0;
        grant_cnt[1] = 0;
    endtask

    task automatic drive_idle();
        bus.r0_valid = 0; bus.r0_we = 0; bus.r0_lock = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_valid = 0; bus.r1_we = 0; bus.r1_lock = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
    endtask

    // One clock cycle: drive requests, check every output, advance the model.
    task automatic do_cycle(input bit v0, input bit we0, input bit l0,
                            input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                            input bit v1, input bit we1, input bit l1,
                            input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        bit                v [2];
        bit                we [2];
        bit                lk [2];
        logic [ADDR_W-1:0] ad [2];
        logic [DATA_W-1:0] dt [2];
        int                g;
        @(negedge clk);
        bus.r0_valid = v0; bus.r0_we = we0; bus.r0_lock = l0; bus.r0_addr = a0; bus.r0_wdata = d0;
        bus.r1_valid = v1; bus.r1_we = we1; bus.r1_lock = l1; bus.r1_addr = a1; bus.r1_wdata = d1;
        v[0] = v0; we[0] = we0; lk[0] = l0; ad[0] = a0; dt[0] = d0;
        v[1] = v1; we[1] = we1; lk[1] = l1; ad[1] = a1; dt[1] = d1;
        #1;
        if (mdl_hold < 0) begin
            if (v[0] && v[1]) g = mdl_prio;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
            else              g = -1;
        end else begin
            g = v[mdl_hold] ? mdl_hold : -1;
        end

        check("r0_ready", {31'd0, bus.r0_ready}, {31'd0, g == 0});
        check("r1_ready", {31'd0, bus.r1_ready}, {31'd0, g == 1});
        check("mem_ce",   {31'd0, bus.mem_ce},   {31'd0, g >= 0});
        check("mem_we",   {31'd0, bus.mem_we},   {31'd0, (g >= 0) ? we[g] : 1'b0});
        check("mem_addr", {18'd0, bus.mem_addr}, (g >= 0) ? {18'd0, ad[g]} : '0);
        check("mem_din",  bus.mem_din,           (g >= 0) ? dt[g] : '0);
        check("r0_rsp_valid", {31'd0, bus.r0_rsp_valid}, {31'd0, exp_owner == 0});
        check("r1_rsp_valid", {31'd0, bus.r1_rsp_valid}, {31'd0, exp_owner == 1});
        check("r0_rdata", bus.r0_rdata, (exp_owner == 0) ? exp_data : '0);
        check("r1_rdata", bus.r1_rdata, (exp_owner == 1) ? exp_data : '0);
        if (exp_owner >= 0) void'(exp_q.pop_front());

        // advance model to the next edge
        exp_owner = -1;
        if (g >= 0) begin
            if (grant_cnt[g] < 32'h0000_FFFF) grant_cnt[g]++;
            if (we[g]) begin
                mdl_mem[ad[g]] = dt[g];
            end else begin
                exp_owner = g;
                exp_data  = mdl_mem[ad[g]];
                exp_q.push_back(exp_data);
            end
        end
        if (mdl_hold < 0) begin
            if (g >= 0) begin
                mdl_prio = 1 - g;
                if (lk[g]) mdl_hold = g;
            end
        end else if (!v[mdl_hold] || !lk[mdl_hold]) begin
            mdl_hold = -1;
        end
    endtask

    // Asynchronous reset pulse asserted mid-cycle and held across one edge.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1;
        bus.r0_valid = 1; bus.r1_valid = 1;
        #1;
        check("rst_r0_ready", {31'd0, bus.r0_ready}, '0);
        check("rst_r1_ready", {31'd0, bus.r1_ready}, '0);
        check("rst_mem_ce",   {31'd0, bus.mem_ce},   '0);
        check("rst_r1_rsp",   {31'd0, bus.r1_rsp_valid}, '0);
        @(posedge clk); #1;
        check("rst_r0_rsp",   {31'd0, bus.r0_rsp_valid}, '0);
        check("rst_mem_we",   {31'd0, bus.mem_we},   '0);
        check("rst_r0_rdata", bus.r0_rdata, '0);
        check("rst_r1_rdata", bus.r1_rdata, '0);
        @(negedge clk);
        reset = 0;
        drive_idle();
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = '0;
            mdl_mem[i] = '0;
        end
        drive_idle();
        bus.mem_dout = '0;
`ifdef RAM_ARB_STATS_EN
        stat_sel = 0;
`endif
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        pulse_reset();

        // write then read the same word from r0
        do_cycle(1, 1, 0, 14'h0010, 32'hDEADBEEF, 0, 0, 0, '0, '0);
        do_cycle(1, 0, 0, 14'h0010, '0,           0, 0, 0, '0, '0);
        do_cycle(0, 0, 0, '0, '0,                 0, 0, 0, '0, '0);
        check("wr_rd_r0_rsp",   {31'd0, bus.r0_rsp_valid}, 32'd1);
        check("wr_rd_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
        check("wr_rd_r1_rsp",   {31'd0, bus.r1_rsp_valid}, 32'd0);

        // alternating continuous reads, then read-before-write ordering
        pulse_reset();
        for (int i = 0; i < 6; i++)
            do_cycle(1, 0, 0, 14'(i), '0, 1, 0, 0, 14'(i + 8), '0);
        do_cycle(1, 0, 0, 14'h0010, '0, 0, 0, 0, '0, '0);
        do_cycle(0, 0, 0, '0, '0, 1, 1, 0, 14'h0010, 32'h1234_5678);
        do_cycle(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);

        // r1 locks for four cycles while r0 keeps requesting
        pulse_reset();
        do_cycle(1, 0, 0, 14'h1, '0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++)
            do_cycle(1, 0, 0, 14'h2, '0, 1, 1, 1, 14'(i + 3), 32'(i));
        for (int i = 0; i < 2; i++)
            do_cycle(1, 0, 0, 14'h2, '0, 0, 0, 0, '0, '0);

        // reset right after an accepted r1 read
        do_cycle(0, 0, 0, '0, '0, 1, 0, 0, 14'h5, '0);
        pulse_reset();
        do_cycle(1, 0, 0, 14'h6, '0, 1, 0, 0, 14'h7, '0);
        check("post_rst_first_r0", {31'd0, bus.r0_ready}, 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                         14'($urandom_range(0, 15)), $urandom,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                         14'($urandom_range(0, 15)), $urandom);
            end
        end

`ifdef RAM_ARB_STATS_EN
        pulse_reset();
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            bus.r0_valid = 1; bus.r0_we = 1; bus.r0_lock = 0;
            bus.r0_addr = 14'h20; bus.r0_wdata = 32'(i);
            bus.r1_valid = 0;
            #1;
            if (bus.r0_ready && grant_cnt[0] < 32'h0000_FFFF) grant_cnt[0]++;
        end
        mdl_mem[14'h20] = 32'(69999);
        @(negedge clk);
        drive_idle();
        stat_sel = 0;
        #1;
        check("stat_r0", {16'd0, stat_count}, 32'h0000_FFFF);
        check("stat_r0_model", {16'd0, stat_count}, 32'(grant_cnt[0]));
        stat_sel = 1;
        #1;
        check("stat_r1", {16'd0, stat_count}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
